// File: rtl/stage_decode_queued.sv
// rtl/stage_decode_queued.sv - RV32I decode stage feeding EX through a DEPTH-entry queue of decoded ops
// Purpose: decodes instr_i into operands/control, builds immediates plus branch and JAL
//   targets, and buffers the resulting ID/EX entries in a valid/ready FIFO. Holds IF off
//   while a queued writer targets a source register of the incoming instruction.
// Ports:
//   clk, rst_ni                 clock, asynchronous active-low reset
//   squash_i                    flush all queued ops and drop this cycle's input
//   if_valid_i / if_ready_o     IF handshake
//   instr_i                     instruction word
//   if_pc_i, if_pc_plus_four_i  pc and pc+4 from IF
//   if_id_valid_i               valid bit from IF, copied into the entry
//   rs1_addr_o / rs2_addr_o     regfile read addresses
//   data_rs1_i / data_rs2_i     regfile read data, same cycle
//   ex_valid_o / ex_ready_i     EX handshake on the queue head
//   ex_*_o                      fields of the queue head entry
//   jal_o / jal_addr_o          JAL accepted this cycle and its target
module stage_decode_queued #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst_ni,
   input  logic            squash_i,
   input  logic            if_valid_i,
   output logic            if_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] if_pc_i,
   input  logic [XLEN-1:0] if_pc_plus_four_i,
   input  logic            if_id_valid_i,
   output logic [4:0]      rs1_addr_o,
   output logic [4:0]      rs2_addr_o,
   input  logic [XLEN-1:0] data_rs1_i,
   input  logic [XLEN-1:0] data_rs2_i,
   output logic            ex_valid_o,
   input  logic            ex_ready_i,
   output logic            ex_uop_valid_o,
   output logic [XLEN-1:0] ex_alu_op1_o,
   output logic [XLEN-1:0] ex_alu_op2_o,
   output logic [XLEN-1:0] ex_dmem_data_o,
   output logic [XLEN-1:0] ex_branch_addr_o,
   output logic [XLEN-1:0] ex_pc_plus_four_o,
   output logic [2:0]      ex_func3_o,
   output logic [3:0]      ex_alu_fun_o,
   output logic            ex_mem_rd_o,
   output logic            ex_mem_wr_o,
   output logic            ex_reg_wr_en_o,
   output logic [4:0]      ex_reg_wr_addr_o,
   output logic [1:0]      ex_wb_sel_o,
   output logic            ex_branch_o,
   output logic            ex_jalr_o,
   output logic            jal_o,
   output logic [XLEN-1:0] jal_addr_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // alu_fun is {instr[30], func3} for arithmetic; COPY1 passes alu_op1 through (LUI)
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b1000;
   localparam logic [3:0] ALU_COPY1 = 4'b1111;

   localparam logic [1:0] OP2_RS2  = 2'd0;
   localparam logic [1:0] OP2_IIMM = 2'd1;
   localparam logic [1:0] OP2_SIMM = 2'd2;
   localparam logic [1:0] OP2_PC   = 2'd3;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] alu_op1;
      logic [XLEN-1:0] alu_op2;
      logic [XLEN-1:0] dmem_data;
      logic [XLEN-1:0] branch_addr;
      logic [XLEN-1:0] pc_plus_four;
      logic [2:0]      func3;
      logic [3:0]      alu_fun;
      logic            mem_rd;
      logic            mem_wr;
      logic            reg_wr_en;
      logic [4:0]      reg_wr_addr;
      logic [1:0]      wb_sel;
      logic            branch;
      logic            jalr;
   } entry_t;

   logic [6:0]      opcode;
   logic [2:0]      func3;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            op1_sel;
   logic [1:0]      op2_sel;
   logic [3:0]      alu_fun;
   logic            mem_rd, mem_wr, reg_wr_en, branch, jalr, instr_jal;
   logic [1:0]      wb_sel;
   logic            use_rs1, use_rs2;
   entry_t          new_entry;

   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0] occ_q, occ_d;
   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   entry_t          head;
   logic            raw_hazard, push, pop;

   assign opcode     = instr_i[6:0];
   assign func3      = instr_i[14:12];
   assign rs1_addr_o = instr_i[19:15];
   assign rs2_addr_o = instr_i[24:20];

   assign imm_i = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
   assign imm_s = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign imm_u = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};
   assign imm_j = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

   always_comb begin
      op1_sel   = 1'b0;
      op2_sel   = OP2_RS2;
      alu_fun   = ALU_ADD;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      reg_wr_en = 1'b0;
      wb_sel    = WB_ALU;
      branch    = 1'b0;
      jalr      = 1'b0;
      instr_jal = 1'b0;
      use_rs1   = 1'b1;
      use_rs2   = 1'b0;
      case (opcode)
         OPC_LUI:    begin op1_sel = 1'b1; alu_fun = ALU_COPY1; reg_wr_en = 1'b1; use_rs1 = 1'b0; end
         OPC_AUIPC:  begin op1_sel = 1'b1; op2_sel = OP2_PC; reg_wr_en = 1'b1; use_rs1 = 1'b0; end
         OPC_JAL:    begin reg_wr_en = 1'b1; wb_sel = WB_PC4; instr_jal = 1'b1; use_rs1 = 1'b0; end
         OPC_JALR:   begin op2_sel = OP2_IIMM; reg_wr_en = 1'b1; wb_sel = WB_PC4; jalr = 1'b1; end
         OPC_BRANCH: begin alu_fun = ALU_SUB; branch = 1'b1; use_rs2 = 1'b1; end
         OPC_LOAD:   begin op2_sel = OP2_IIMM; mem_rd = 1'b1; reg_wr_en = 1'b1; wb_sel = WB_MEM; end
         OPC_STORE:  begin op2_sel = OP2_SIMM; mem_wr = 1'b1; use_rs2 = 1'b1; end
         // only SRLI/SRAI take instr[30] as a function bit; for other OP-IMMs it is immediate
         OPC_OPIMM:  begin op2_sel = OP2_IIMM; alu_fun = {(func3 == 3'b101) & instr_i[30], func3}; reg_wr_en = 1'b1; end
         OPC_OP:     begin alu_fun = {instr_i[30], func3}; reg_wr_en = 1'b1; use_rs2 = 1'b1; end
         default:    begin use_rs1 = 1'b1; end
      endcase
   end

   always_comb begin
      new_entry              = '0;
      new_entry.valid        = if_id_valid_i;
      new_entry.alu_op1      = op1_sel ? imm_u : data_rs1_i;
      case (op2_sel)
         OP2_IIMM: new_entry.alu_op2 = imm_i;
         OP2_SIMM: new_entry.alu_op2 = imm_s;
         OP2_PC:   new_entry.alu_op2 = if_pc_i;
         default:  new_entry.alu_op2 = data_rs2_i;
      endcase
      new_entry.dmem_data    = data_rs2_i;
      new_entry.branch_addr  = if_pc_i + imm_b;
      new_entry.pc_plus_four = if_pc_plus_four_i;
      new_entry.func3        = func3;
      new_entry.alu_fun      = alu_fun;
      new_entry.mem_rd       = mem_rd;
      new_entry.mem_wr       = mem_wr;
      new_entry.reg_wr_en    = reg_wr_en;
      new_entry.reg_wr_addr  = instr_i[11:7];
      new_entry.wb_sel       = wb_sel;
      new_entry.branch       = branch;
      new_entry.jalr         = jalr;
   end

   // Every occupied slot is checked, including the head being popped this cycle: its
   // result is not yet in the regfile when this instruction would read operands.
   always_comb begin
      raw_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (occ_q[i] && mem_q[i].reg_wr_en && (mem_q[i].reg_wr_addr != 5'd0) &&
             ((use_rs1 && (mem_q[i].reg_wr_addr == rs1_addr_o)) ||
              (use_rs2 && (mem_q[i].reg_wr_addr == rs2_addr_o))))
            raw_hazard = 1'b1;
      end
   end

   assign head       = mem_q[rd_ptr_q];
   assign ex_valid_o = (count_q != '0);
   assign if_ready_o = rst_ni & (count_q < CW'(DEPTH)) & ~raw_hazard;
   assign push       = if_valid_i & if_ready_o & ~squash_i;
   assign pop        = ex_valid_o & ex_ready_i & ~squash_i;
   assign jal_o      = push & instr_jal;
   assign jal_addr_o = if_pc_i + imm_j;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      occ_d    = occ_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (squash_i) begin
         occ_d    = '0;
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (pop) begin
            occ_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
         end
         if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            occ_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign ex_uop_valid_o    = head.valid;
   assign ex_alu_op1_o      = head.alu_op1;
   assign ex_alu_op2_o      = head.alu_op2;
   assign ex_dmem_data_o    = head.dmem_data;
   assign ex_branch_addr_o  = head.branch_addr;
   assign ex_pc_plus_four_o = head.pc_plus_four;
   assign ex_func3_o        = head.func3;
   assign ex_alu_fun_o      = head.alu_fun;
   assign ex_mem_rd_o       = head.mem_rd;
   assign ex_mem_wr_o       = head.mem_wr;
   assign ex_reg_wr_en_o    = head.reg_wr_en;
   assign ex_reg_wr_addr_o  = head.reg_wr_addr;
   assign ex_wb_sel_o       = head.wb_sel;
   assign ex_branch_o       = head.branch;
   assign ex_jalr_o         = head.jalr;

endmodule

// File: tb/tb_stage_decode_queued.sv
// tb/tb_stage_decode_queued.sv - directed bench for stage_decode_queued
module tb_stage_decode_queued;

   logic        clk = 1'b0;
   logic        rst_ni, squash_i, if_valid_i, if_ready_o;
   logic [31:0] instr_i, if_pc_i, if_pc_plus_four_i;
   logic        if_id_valid_i;
   logic [4:0]  rs1_addr_o, rs2_addr_o;
   logic [31:0] data_rs1_i, data_rs2_i;
   logic        ex_valid_o, ex_ready_i, ex_uop_valid_o;
   logic [31:0] ex_alu_op1_o, ex_alu_op2_o, ex_dmem_data_o, ex_branch_addr_o, ex_pc_plus_four_o;
   logic [2:0]  ex_func3_o;
   logic [3:0]  ex_alu_fun_o;
   logic        ex_mem_rd_o, ex_mem_wr_o, ex_reg_wr_en_o;
   logic [4:0]  ex_reg_wr_addr_o;
   logic [1:0]  ex_wb_sel_o;
   logic        ex_branch_o, ex_jalr_o, jal_o;
   logic [31:0] jal_addr_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stage_decode_queued dut (
      .clk(clk), .rst_ni(rst_ni), .squash_i(squash_i),
      .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .instr_i(instr_i),
      .if_pc_i(if_pc_i), .if_pc_plus_four_i(if_pc_plus_four_i), .if_id_valid_i(if_id_valid_i),
      .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
      .data_rs1_i(data_rs1_i), .data_rs2_i(data_rs2_i),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_uop_valid_o(ex_uop_valid_o),
      .ex_alu_op1_o(ex_alu_op1_o), .ex_alu_op2_o(ex_alu_op2_o), .ex_dmem_data_o(ex_dmem_data_o),
      .ex_branch_addr_o(ex_branch_addr_o), .ex_pc_plus_four_o(ex_pc_plus_four_o),
      .ex_func3_o(ex_func3_o), .ex_alu_fun_o(ex_alu_fun_o),
      .ex_mem_rd_o(ex_mem_rd_o), .ex_mem_wr_o(ex_mem_wr_o), .ex_reg_wr_en_o(ex_reg_wr_en_o),
      .ex_reg_wr_addr_o(ex_reg_wr_addr_o), .ex_wb_sel_o(ex_wb_sel_o),
      .ex_branch_o(ex_branch_o), .ex_jalr_o(ex_jalr_o),
      .jal_o(jal_o), .jal_addr_o(jal_addr_o)
   );

   function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'h13};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      if_valid_i        = v;
      instr_i           = ins;
      if_pc_i           = pc;
      if_pc_plus_four_i = pc + 32'd4;
      if_id_valid_i     = 1'b1;
   endtask

   task automatic test_reset();
      drive(1'b1, 32'h020000EF, 32'h100);
      #3;
      checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL rst_if_ready got %b exp 0", if_ready_o); end
      checks++; if (jal_o !== 1'b0) begin errors++; $display("FAIL rst_jal got %b exp 0", jal_o); end
      checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL rst_ex_valid got %b exp 0", ex_valid_o); end
      cyc(); cyc();
      if_valid_i = 1'b0;
      rst_ni = 1'b1;
      #1;
      checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL rst_rel_ready got %b exp 1", if_ready_o); end
      checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rel_ex_valid got %b exp 0", ex_valid_o); end
   endtask

   task automatic test_throughput();
      ex_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         drive(1'b1, enc_addi(5'(10 + k), 5'd1, 12'(k + 1)), 32'h200 + 32'(4 * k));
         #1;
         checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL tp_ready%0d got %b exp 1", k, if_ready_o); end
         if (k == 0) begin
            checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL tp_first_valid got %b exp 0", ex_valid_o); end
         end else begin
            checks++; if (ex_valid_o !== 1'b1) begin errors++; $display("FAIL tp_valid%0d got %b exp 1", k, ex_valid_o); end
            checks++; if (ex_reg_wr_addr_o !== 5'(9 + k)) begin errors++; $display("FAIL tp_rd%0d got %0d exp %0d", k, ex_reg_wr_addr_o, 9 + k); end
            checks++; if (ex_alu_op2_o !== 32'(k)) begin errors++; $display("FAIL tp_op2_%0d got %h exp %h", k, ex_alu_op2_o, k); end
         end
      end
      cyc();
      if_valid_i = 1'b0;
      #1;
      checks++; if (ex_reg_wr_addr_o !== 5'd13) begin errors++; $display("FAIL tp_last_rd got %0d exp 13", ex_reg_wr_addr_o); end
      checks++; if (ex_alu_op1_o !== 32'h1000) begin errors++; $display("FAIL tp_op1 got %h exp 00001000", ex_alu_op1_o); end
      checks++; if (ex_pc_plus_four_o !== 32'h210) begin errors++; $display("FAIL tp_ppf got %h exp 00000210", ex_pc_plus_four_o); end
      checks++; if (ex_reg_wr_en_o !== 1'b1 || ex_uop_valid_o !== 1'b1) begin errors++; $display("FAIL tp_ctrl got %b%b exp 11", ex_reg_wr_en_o, ex_uop_valid_o); end
      cyc();
      checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL tp_drain got %b exp 0", ex_valid_o); end
      ex_ready_i = 1'b0;
   endtask

   task automatic test_branch_store();
      cyc(); drive(1'b1, 32'h00208863, 32'h300);
      cyc(); drive(1'b1, 32'h00020A423 , 32'h304);
      #1;
      checks++; if (ex_branch_o !== 1'b1) begin errors++; $display("FAIL br_flag got %b exp 1", ex_branch_o); end
      checks++; if (ex_branch_addr_o !== 32'h310) begin errors++; $display("FAIL br_addr got %h exp 00000310", ex_branch_addr_o); end
      checks++; if (ex_alu_op2_o !== 32'h2000) begin errors++; $display("FAIL br_op2 got %h exp 00002000", ex_alu_op2_o); end
      checks++; if (ex_reg_wr_en_o !== 1'b0) begin errors++; $display("FAIL br_wr_en got %b exp 0", ex_reg_wr_en_o); end
      cyc(); if_valid_i = 1'b0; ex_ready_i = 1'b1;
      cyc();
      checks++; if (ex_mem_wr_o !== 1'b1 || ex_mem_rd_o !== 1'b0) begin errors++; $display("FAIL st_mem got wr%b rd%b exp wr1 rd0", ex_mem_wr_o, ex_mem_rd_o); end
      checks++; if (ex_alu_op2_o !== 32'h8) begin errors++; $display("FAIL st_op2 got %h exp 00000008", ex_alu_op2_o); end
      checks++; if (ex_dmem_data_o !== 32'h2000) begin errors++; $display("FAIL st_data got %h exp 00002000", ex_dmem_data_o); end
      checks++; if (ex_func3_o !== 3'd2) begin errors++; $display("FAIL st_func3 got %0d exp 2", ex_func3_o); end
      cyc(); drive(1'b1, 32'hFFF08193, 32'h308);
      cyc(); if_valid_i = 1'b0;
      checks++; if (ex_alu_op2_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL neg_imm got %h exp ffffffff", ex_alu_op2_o); end
      cyc();
      checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL bs_drain got %b exp 0", ex_valid_o); end
      ex_ready_i = 1'b0;
   endtask

   task automatic test_backpressure();
      cyc(); drive(1'b1, enc_addi(5'd20, 5'd1, 12'd1), 32'h600);
      cyc(); drive(1'b1, enc_addi(5'd21, 5'd1, 12'd2), 32'h604);
      #1;
      checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", if_ready_o); end
      cyc(); drive(1'b1, enc_addi(5'd22, 5'd1, 12'd3), 32'h608);
      #1;
      checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", if_ready_o); end
      cyc(); ex_ready_i = 1'b1;
      #1;
      checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL bp_no_comb got %b exp 0", if_ready_o); end
      checks++; if (ex_reg_wr_addr_o !== 5'd20) begin errors++; $display("FAIL bp_head0 got %0d exp 20", ex_reg_wr_addr_o); end
      cyc();
      checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready2 got %b exp 1", if_ready_o); end
      checks++; if (ex_reg_wr_addr_o !== 5'd21) begin errors++; $display("FAIL bp_head1 got %0d exp 21", ex_reg_wr_addr_o); end
      cyc(); if_valid_i = 1'b0; ex_ready_i = 1'b0;
      #1;
      checks++; if (ex_reg_wr_addr_o !== 5'd22 || ex_valid_o !== 1'b1) begin errors++; $display("FAIL bp_head2 got %0d/%b exp 22/1", ex_reg_wr_addr_o, ex_valid_o); end
      checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL bp_cnt1 got %b exp 1", if_ready_o); end
      cyc(); drive(1'b1, enc_addi(5'd23, 5'd1, 12'd4), 32'h60C);
      cyc(); drive(1'b1, enc_addi(5'd24, 5'd1, 12'd5), 32'h610); ex_ready_i = 1'b1;
      #1;
      checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full2 got %b exp 0", if_ready_o); end
      cyc(); if_valid_i = 1'b0;
      #1;
      checks++; if (ex_reg_wr_addr_o !== 5'd23) begin errors++; $display("FAIL bp_head3 got %0d exp 23", ex_reg_wr_addr_o); end
      cyc();
      checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", ex_valid_o); end
      ex_ready_i = 1'b0;
   endtask

   task automatic test_raw();
      cyc(); drive(1'b1, 32'h00500293, 32'h400);
      cyc(); if_valid_i = 1'b0; instr_i = 32'h00728333;
      #1;
      checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL raw_rs1 got %b exp 0", if_ready_o); end
      checks++; if (rs1_addr_o !== 5'd5 || rs2_addr_o !== 5'd7) begin errors++; $display("FAIL raw_addrs got %0d,%0d exp 5,7", rs1_addr_o, rs2_addr_o); end
      instr_i = 32'h00508513; #1;
      checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL raw_opimm_rs2 got %b exp 1", if_ready_o); end
      instr_i = 32'h000284B7; #1;
      checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL raw_lui got %b exp 1", if_ready_o); end
      instr_i = 32'h0050A023; #1;
      checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL raw_store_rs2 got %b exp 0", if_ready_o); end
      cyc(); drive(1'b1, 32'h00728333, 32'h404); ex_ready_i = 1'b1;
      #1;
      checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL raw_popping got %b exp 0", if_ready_o); end
      cyc(); ex_ready_i = 1'b0;
      #1;
      checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL raw_release got %b exp 1", if_ready_o); end
      cyc(); if_valid_i = 1'b0; ex_ready_i = 1'b1;
      #1;
      checks++; if (ex_reg_wr_addr_o !== 5'd6 || ex_alu_op2_o !== 32'h2000) begin errors++; $display("FAIL raw_add_entry got %0d/%h exp 6/00002000", ex_reg_wr_addr_o, ex_alu_op2_o); end
      cyc(); ex_ready_i = 1'b0; drive(1'b1, 32'h00100013, 32'h408);
      cyc(); if_valid_i = 1'b0; instr_i = 32'h00000333; ex_ready_i = 1'b1;
      #1;
      checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL raw_x0 got %b exp 1", if_ready_o); end
      cyc(); ex_ready_i = 1'b0; drive(1'b1, 32'h000284B7, 32'h500);
      cyc(); if_valid_i = 1'b0; ex_ready_i = 1'b1;
      #1;
      checks++; if (ex_alu_op1_o !== 32'h00028000 || ex_reg_wr_addr_o !== 5'd9) begin errors++; $display("FAIL lui_entry got %h/%0d exp 00028000/9", ex_alu_op1_o, ex_reg_wr_addr_o); end
      cyc(); ex_ready_i = 1'b0;
      checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL raw_drain got %b exp 0", ex_valid_o); end
   endtask

   task automatic test_jal();
      cyc(); drive(1'b1, 32'h020000EF, 32'h100);
      #1;
      checks++; if (jal_o !== 1'b1) begin errors++; $display("FAIL jal_flag got %b exp 1", jal_o); end
      checks++; if (jal_addr_o !== 32'h120) begin errors++; $display("FAIL jal_addr got %h exp 00000120", jal_addr_o); end
      cyc(); if_valid_i = 1'b0; ex_ready_i = 1'b1;
      #1;
      checks++; if (jal_o !== 1'b0) begin errors++; $display("FAIL jal_idle got %b exp 0", jal_o); end
      checks++; if (ex_pc_plus_four_o !== 32'h104 || ex_reg_wr_addr_o !== 5'd1) begin errors++; $display("FAIL jal_entry got %h/%0d exp 00000104/1", ex_pc_plus_four_o, ex_reg_wr_addr_o); end
      cyc(); ex_ready_i = 1'b0; drive(1'b1, 32'h020000EF, 32'h100); squash_i = 1'b1;
      #1;
      checks++; if (jal_o !== 1'b0) begin errors++; $display("FAIL jal_squash got %b exp 0", jal_o); end
      cyc(); squash_i = 1'b0; if_valid_i = 1'b0;
      #1;
      checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL jal_sq_empty got %b exp 0", ex_valid_o); end
   endtask

   task automatic test_squash();
      cyc(); drive(1'b1, enc_addi(5'd20, 5'd1, 12'd1), 32'h700);
      cyc(); drive(1'b1, enc_addi(5'd21, 5'd1, 12'd2), 32'h704);
      cyc(); drive(1'b1, enc_addi(5'd22, 5'd1, 12'd3), 32'h708); squash_i = 1'b1; ex_ready_i = 1'b1;
      #1;
      checks++; if (ex_valid_o !== 1'b1) begin errors++; $display("FAIL sq_before got %b exp 1", ex_valid_o); end
      cyc(); squash_i = 1'b0; ex_ready_i = 1'b0; drive(1'b1, enc_addi(5'd23, 5'd1, 12'd4), 32'h70C);
      #1;
      checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL sq_empty got %b exp 0", ex_valid_o); end
      checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL sq_ready got %b exp 1", if_ready_o); end
      cyc(); if_valid_i = 1'b0;
      #1;
      checks++; if (ex_valid_o !== 1'b1 || ex_reg_wr_addr_o !== 5'd23) begin errors++; $display("FAIL sq_refill got %b/%0d exp 1/23", ex_valid_o, ex_reg_wr_addr_o); end
      ex_ready_i = 1'b1;
      cyc(); ex_ready_i = 1'b0;
      checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL sq_drain got %b exp 0", ex_valid_o); end
   endtask

   task automatic test_reset_mid();
      cyc(); drive(1'b1, enc_addi(5'd20, 5'd1, 12'd1), 32'h800);
      cyc(); drive(1'b1, enc_addi(5'd21, 5'd1, 12'd2), 32'h804);
      cyc(); if_valid_i = 1'b0;
      #1;
      checks++; if (ex_valid_o !== 1'b1) begin errors++; $display("FAIL rm_filled got %b exp 1", ex_valid_o); end
      rst_ni = 1'b0;
      #1;
      checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL rm_async got %b exp 0", ex_valid_o); end
      checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL rm_ready_in_rst got %b exp 0", if_ready_o); end
      cyc(); cyc();
      rst_ni = 1'b1;
      #1;
      checks++; if (if_ready_o !== 1'b1 || ex_valid_o !== 1'b0) begin errors++; $display("FAIL rm_release got %b/%b exp 1/0", if_ready_o, ex_valid_o); end
      drive(1'b1, enc_addi(5'd25, 5'd1, 12'd9), 32'h900);
      cyc(); if_valid_i = 1'b0;
      #1;
      checks++; if (ex_reg_wr_addr_o !== 5'd25 || ex_alu_op2_o !== 32'd9) begin errors++; $display("FAIL rm_push got %0d/%h exp 25/00000009", ex_reg_wr_addr_o, ex_alu_op2_o); end
   endtask

   initial begin
      rst_ni = 1'b0; squash_i = 1'b0; ex_ready_i = 1'b0;
      data_rs1_i = 32'h1000; data_rs2_i = 32'h2000;
      drive(1'b0, 32'h0, 32'h0);
      test_reset();
      test_throughput();
      test_branch_store();
      test_backpressure();
      test_raw();
      test_jal();
      test_squash();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
